// File: rtl/tt_reader.sv
// tt_reader: sweeps all 16 input vectors of a 4-input gate-level circuit.
// For each vector it waits SETTLE cycles, then samples out_s on two cycles
// in a row. The second sample is stored as the truth-table bit and the two
// samples are compared to flag instability.
// truth_table bit (15 - index) holds the result for vector index = {in1,in2,in3,in4}.
// Optional feature: define TT_READER_CHECK_EN to compare the table against 'expected'.
module tt_reader #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  input  logic        out_s,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        unstable
`ifdef TT_READER_CHECK_EN
  ,
  input  logic [15:0] expected,
  output logic        match,
  output logic [4:0]  mismatch_cnt
`endif
);

  localparam logic [7:0] SETTLE_W = 8'(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE_A,
    ST_SAMPLE_B,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  vec;
  logic [7:0]  cnt;
  logic        samp_a;
  logic        start_acc;
  logic        last_vec;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last_vec  = (vec == 4'd15);
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (cnt == 8'd1) state_nxt = ST_SAMPLE_A;
      end
      ST_SAMPLE_A: begin
        busy      = 1'b1;
        state_nxt = ST_SAMPLE_B;
      end
      ST_SAMPLE_B: begin
        busy      = 1'b1;
        state_nxt = last_vec ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Vector drive, settle counter, sample capture and table accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      vec         <= 4'd0;
      cnt         <= 8'd0;
      samp_a      <= 1'b0;
      truth_table <= 16'h0000;
      unstable    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            vec         <= 4'd0;
            cnt         <= SETTLE_W;
            truth_table <= 16'h0000;
            unstable    <= 1'b0;
          end
        end
        ST_SETTLE:   cnt    <= cnt - 8'd1;
        ST_SAMPLE_A: samp_a <= out_s;
        ST_SAMPLE_B: begin
          truth_table[4'd15 - vec] <= out_s;
          if (samp_a != out_s) unstable <= 1'b1;
          // The vector returns to 0000 on the way into DONE, so it never wraps.
          if (last_vec) begin
            vec <= 4'd0;
          end else begin
            vec <= vec + 4'd1;
            cnt <= SETTLE_W;
          end
        end
        default: ;
      endcase
    end
  end

  assign {in1, in2, in3, in4} = vec;

`ifdef TT_READER_CHECK_EN
  logic       bit_diff;
  logic [4:0] mm_nxt;
  logic       unst_nxt;

  assign bit_diff = (out_s != expected[4'd15 - vec]);
  assign mm_nxt   = mismatch_cnt + {4'd0, bit_diff};
  assign unst_nxt = unstable | (samp_a != out_s);

  // Running mismatch count; match is decided as the sweep enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_cnt <= 5'd0;
      match        <= 1'b0;
    end else if (start_acc) begin
      mismatch_cnt <= 5'd0;
      match        <= 1'b0;
    end else if (state == ST_SAMPLE_B) begin
      mismatch_cnt <= mm_nxt;
      if (last_vec) match <= (mm_nxt == 5'd0) && !unst_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tt_reader.sv
// Bench for tt_reader: emulates the circuit under test from a truth function,
// models the sweep by cycle position after start acceptance, and checks every cycle.
module tb_tt_reader;

  localparam int S    = 4;
  localparam int VC   = S + 2;
  localparam int NCYC = 16 * VC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        in1, in2, in3, in4;
  logic        out_s;
  logic        busy, done, unstable;
  logic [15:0] truth_table;
  logic        u1_in1, u1_in2, u1_in3, u1_in4;
  logic        u1_busy, u1_done, u1_unstable;
  logic [15:0] u1_table;
`ifdef TT_READER_CHECK_EN
  logic        match, u1_match;
  logic [4:0]  mismatch_cnt, u1_mm;
`endif

  logic [15:0] cut_f = 16'h47FD;
  logic [15:0] expected_v = 16'h47FD;
  logic        glitch_en = 1'b0;
  logic [3:0]  gidx = 4'd0;
  logic        chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_tbl = 16'h0;
  logic        m_unst = 1'b0;
  logic [4:0]  m_mm = 5'd0;
  logic        m_match = 1'b0;

  int          m_v, m_pos;
  logic        m_sa, m_sb, in_samp_b;
  logic        exp_busy, exp_done;
  logic [3:0]  exp_vec, idx_pins;

  assign m_v       = (m_k - 1) / VC;
  assign m_pos     = (m_k - 1) % VC;
  assign m_sa      = cut_f[4'(15 - m_v)];
  assign m_sb      = m_sa ^ (glitch_en && (4'(m_v) == gidx));
  assign in_samp_b = m_active && (m_k <= NCYC) && (m_pos == VC - 1);
  assign exp_busy  = m_active && (m_k <= NCYC);
  assign exp_done  = m_active && (m_k == NCYC + 1);
  assign exp_vec   = exp_busy ? 4'(m_v) : 4'd0;

  // Circuit under test: truth function of the driven vector, optionally
  // flipped during the second sample cycle of one chosen vector.
  assign idx_pins = {in1, in2, in3, in4};
  assign out_s = cut_f[4'd15 - idx_pins] ^ (glitch_en && (idx_pins == gidx) && in_samp_b);

  tt_reader #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out_s(out_s), .busy(busy), .done(done),
    .truth_table(truth_table), .unstable(unstable)
`ifdef TT_READER_CHECK_EN
    , .expected(expected_v), .match(match), .mismatch_cnt(mismatch_cnt)
`endif
  );

  tt_reader #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .in1(u1_in1), .in2(u1_in2), .in3(u1_in3), .in4(u1_in4),
    .out_s(1'b0), .busy(u1_busy), .done(u1_done),
    .truth_table(u1_table), .unstable(u1_unstable)
`ifdef TT_READER_CHECK_EN
    , .expected(16'h47FD), .match(u1_match), .mismatch_cnt(u1_mm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: cycle k after the accept edge lies in vector (k-1)/VC at position (k-1)%VC
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0; m_k <= 0; m_tbl <= 16'h0; m_unst <= 1'b0;
      m_mm <= 5'd0; m_match <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_k <= 1; m_tbl <= 16'h0; m_unst <= 1'b0;
        m_mm <= 5'd0; m_match <= 1'b0;
      end
    end else begin
      if (in_samp_b) begin
        m_tbl[15 - m_v] <= m_sb;
        if (m_sa != m_sb) m_unst <= 1'b1;
        m_mm <= m_mm + 5'(m_sb != expected_v[15 - m_v]);
        if (m_v == 15)
          m_match <= ((m_mm + 5'(m_sb != expected_v[15 - m_v])) == 5'd0) && !(m_unst || (m_sa != m_sb));
      end
      if (m_k == NCYC + 1) begin
        m_active <= 1'b0; m_k <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("vector", 32'(idx_pins), 32'(exp_vec));
      check("table", 32'(truth_table), 32'(m_tbl));
      check("unstable", 32'(unstable), 32'(m_unst));
`ifdef TT_READER_CHECK_EN
      check("match", 32'(match), 32'(m_match));
      check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mm));
`endif
    end
  end

  // One sweep: optional extra start during vector ps_vec (<0 disables) and in DONE
  task automatic run_sweep(input logic [15:0] f, input logic gl, input logic [3:0] gi,
                           input logic [15:0] ex, input int ps_vec, input logic sid,
                           output int ncyc);
    int  n = 0;
    bit  got = 0;
    int  ps = (ps_vec < 0) ? -1 : ps_vec * VC + 2;
    cut_f = f; glitch_en = gl; gidx = gi; expected_v = ex;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    if (done) got = 1;
    while (!got && n < NCYC + 50) begin
      @(negedge clk); n++;
      if (done) begin got = 1; start = sid; end
      else start = (n == ps);
    end
    @(negedge clk); start = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", n, NCYC + 1);
    end
    ncyc = n;
    check("done_cycle", 32'(n), 32'(NCYC + 1));
  endtask

  initial begin
    int nc;
    logic [15:0] f, ex;
    logic gl;
    logic [3:0] gi;

    rst = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_table", 32'(truth_table), 32'h0);
    check("rst_vec", 32'(idx_pins), 32'd0);
    @(negedge clk); rst = 1'b0;

    // NOR/NOT network with truth table 0x47FD
    run_sweep(16'h47FD, 1'b0, 4'd0, 16'h47FD, -1, 1'b0, nc);
    check("p_done97", 32'(nc), 32'd97);
    check("p_table47FD", 32'(truth_table), 32'h47FD);
    check("p_stable", 32'(unstable), 32'd0);
`ifdef TT_READER_CHECK_EN
    check("p_match", 32'(match), 32'd1);
    check("p_mm0", 32'(mismatch_cnt), 32'd0);
`endif

    // Glitch on index 5: second sample inverted, table bit 10 follows sample B
    run_sweep(16'h47FD, 1'b1, 4'd5, 16'h47FD, -1, 1'b0, nc);
    check("g_unstable", 32'(unstable), 32'd1);
    check("g_table", 32'(truth_table), 32'h43FD);
`ifdef TT_READER_CHECK_EN
    check("g_match", 32'(match), 32'd0);
`endif

    // Extra start during index 7 and in DONE must be ignored
    run_sweep(16'hA5C3, 1'b0, 4'd0, 16'hA5C3, 7, 1'b1, nc);
    check("rs_table", 32'(truth_table), 32'hA5C3);
    @(negedge clk);
    check("rs_idle", 32'(busy), 32'd0);

    // Reset during index 9 discards the sweep
    cut_f = 16'h1234; glitch_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9 * VC + 2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mr_vec", 32'(idx_pins), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_table", 32'(truth_table), 32'h0);
    repeat (NCYC) @(negedge clk);
    run_sweep(16'h1234, 1'b0, 4'd0, 16'h1234, -1, 1'b0, nc);
    check("mr_restart", 32'(truth_table), 32'h1234);

    // start together with rst stays idle
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check("sr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("sr_busy2", 32'(busy), 32'd0);

    // Randomised sweeps
    for (int r = 0; r < 6; r++) begin
      f  = 16'($urandom);
      gl = 1'($urandom_range(0, 1));
      gi = 4'($urandom_range(0, 15));
      ex = ($urandom_range(0, 1) == 1) ? f : 16'($urandom);
      run_sweep(f, gl, gi, ex, $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), nc);
      check("rnd_table", 32'(truth_table), 32'(f ^ (gl ? (16'h8000 >> gi) : 16'h0)));
      check("rnd_unstable", 32'(unstable), 32'(gl));
    end

    // SETTLE=1 instance with out_s tied low
    begin
      int  n = 0;
      bit  got = 0;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; n = 1;
      if (u1_done) got = 1;
      while (!got && n < 200) begin
        @(negedge clk); n++;
        if (u1_done) got = 1;
      end
      check("s1_done49", 32'(n), 32'd49);
      check("s1_table", 32'(u1_table), 32'h0);
      check("s1_stable", 32'(u1_unstable), 32'd0);
`ifdef TT_READER_CHECK_EN
      check("s1_mm11", 32'(u1_mm), 32'd11);
      check("s1_match", 32'(u1_match), 32'd0);
`endif
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
